// File: rtl/wb_pipe_slice.sv
// Registered pipelined-Wishbone slice: 2-entry request skid buffer plus response register stage.
// Latency: request accept -> m_stb_o one cycle later at the earliest; m_ack_i -> s_ack_o exactly one cycle.
// Backpressure: s_stall_o (registered) rises when SKID fills or the in-flight count reaches OUTSTANDING_MAX.
module wb_pipe_slice #(
  parameter int OUTSTANDING_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] s_addr_i,
  input  logic [31:0] s_dat_i,
  input  logic [3:0]  s_sel_i,
  input  logic [2:0]  s_cti_i,
  input  logic        s_we_i,
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  output logic        s_stall_o,
  output logic        s_ack_o,
  output logic [31:0] s_dat_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  output logic [2:0]  m_cti_o,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic        m_stall_i,
  input  logic        m_ack_i,
  input  logic [31:0] m_dat_i,
  output logic        err_o
);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic        we;
  } req_t;

  req_t       in_req;
  req_t       main_q;
  req_t       main_d;
  req_t       skid_q;
  req_t       skid_d;
  logic       main_vld;
  logic       main_vld_d;
  logic       skid_vld;
  logic       skid_vld_d;
  logic       accept;
  logic       consume;
  logic       main_free;
  logic       orphan;
  logic [3:0] out_cnt;
  logic [3:0] out_cnt_d;
  logic [3:0] pend_cnt;
  logic [3:0] pend_cnt_d;

  assign in_req    = '{addr: s_addr_i, dat: s_dat_i, sel: s_sel_i, cti: s_cti_i, we: s_we_i};
  assign accept    = s_cyc_i & s_stb_i & ~s_stall_o;
  assign consume   = main_vld & ~m_stall_i;
  assign main_free = ~main_vld | consume;
  // An ack with nothing issued downstream is a slave protocol violation.
  assign orphan    = m_ack_i & (pend_cnt == 4'd0);

  assign m_addr_o = main_q.addr;
  assign m_dat_o  = main_q.dat;
  assign m_sel_o  = main_q.sel;
  assign m_cti_o  = main_q.cti;
  assign m_we_o   = main_q.we;
  assign m_stb_o  = main_vld;

  // Buffer steering: SKID always drains into a freed MAIN before any new request.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld;
    skid_d     = skid_q;
    skid_vld_d = skid_vld;
    if (main_free) begin
      if (skid_vld) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = accept;
        if (accept) begin
          skid_d = in_req;
        end
      end else begin
        main_vld_d = accept;
        if (accept) begin
          main_d = in_req;
        end
      end
    end else if (accept) begin
      // Stall was low, so SKID is known to be empty here.
      skid_d     = in_req;
      skid_vld_d = 1'b1;
    end
  end

  // Upstream in-flight and downstream pending counts; both hold on simultaneous inc/dec and floor at zero.
  always_comb begin
    out_cnt_d = out_cnt;
    if (accept && !s_ack_o) begin
      out_cnt_d = out_cnt + 4'd1;
    end else if (!accept && s_ack_o && (out_cnt != 4'd0)) begin
      out_cnt_d = out_cnt - 4'd1;
    end
    pend_cnt_d = pend_cnt;
    if (consume && !m_ack_i) begin
      pend_cnt_d = pend_cnt + 4'd1;
    end else if (!consume && m_ack_i && (pend_cnt != 4'd0)) begin
      pend_cnt_d = pend_cnt - 4'd1;
    end
  end

  // Request buffer state; reset discards anything held.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_vld <= main_vld_d;
      skid_vld <= skid_vld_d;
    end
  end

  // Counters plus registered stall/cyc derived from end-of-cycle state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_cnt   <= 4'd0;
      pend_cnt  <= 4'd0;
      s_stall_o <= 1'b0;
      m_cyc_o   <= 1'b0;
    end else begin
      out_cnt   <= out_cnt_d;
      pend_cnt  <= pend_cnt_d;
      s_stall_o <= skid_vld_d | (out_cnt_d == 4'(OUTSTANDING_MAX));
      m_cyc_o   <= main_vld_d | (pend_cnt_d != 4'd0);
    end
  end

  // Response register stage; read data holds between acks, error flag is sticky.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s_ack_o <= 1'b0;
      s_dat_o <= 32'd0;
      err_o   <= 1'b0;
    end else begin
      s_ack_o <= m_ack_i;
      if (m_ack_i) begin
        s_dat_o <= m_dat_i;
      end
      if (orphan) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule
